mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS control unit. It is the initiator side of the register file: it drives read addresses, write address and RegWrite, plus the datapath/memory control strobes.
- Sits between the instruction register (IR) and the datapath.
- Moore FSM with a memory ready handshake; one instruction takes 3–5 states plus any memory stall cycles.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch-if-equal
- OP_J, 6'h02, jump
- OP_ADDI, 6'h08, add immediate (used only with the optional feature)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  current IR contents (held stable by the IR)
- mem_ready  in  1  memory done; qualifies FETCH, MEMRD and MEMWR
- readRegA  out  5  instr[25:21], combinational
- readRegB  out  5  instr[20:16], combinational
- writeReg  out  5  RegDst ? instr[15:11] : instr[20:16]
- RegWrite  out  1  register file write enable
- RegDst, MemtoReg, IorD, ALUSrcA  out  1 each  datapath muxes
- ALUSrcB, ALUOp, PCSource  out  2 each
- MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond  out  1 each
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Reset: rst_n=0 immediately forces state=FETCH (0). While rst_n=0, RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite and illegal_op are forced 0. All other outputs follow FETCH decode.
- Outputs are Moore (decoded from state only), except:
  - readRegA/readRegB/writeReg, which are combinational from instr;
  - the mem_ready qualifiers listed below.
- Unlisted outputs are 0 in every state.
- State encodings and outputs:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Register file reads rs/rt during this cycle; regA/regB are valid at the following posedge. Next state by opcode:
    - LW/SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - anything else -> FETCH, with illegal_op=1 for this cycle
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW.
  - MEMRD=3: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=(writeReg!=0). Goes to FETCH.
  - MEMWR=5: MemWrite=1, IorD=1. Holds until mem_ready, then goes to FETCH. MemWrite stays high for every held cycle.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - ALUWB=7: RegDst=1, MemtoReg=0, RegWrite=(writeReg!=0). Goes to FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
  - JUMP=9: PCWrite=1, PCSource=10. Goes to FETCH.
- Register 0 protection: RegWrite is never asserted when writeReg==0; r0 stays architecturally zero.
- Illegal encodings 10–15 (12–15 with the optional feature enabled) go to FETCH next cycle with all strobes 0.
- Latency: J/BEQ take 3 cycles; R-type and SW take 4; LW takes 5. Add one cycle per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset mid-instruction aborts it. No partial RegWrite occurs after rst_n falls.

Optional Feature:
- MC_IMM_ALU_EN defined: opcode OP_ADDI in DECODE goes to IEXEC then IWB.
  - IEXEC=10: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - IWB=11: RegDst=0, MemtoReg=0, RegWrite=(writeReg!=0), then FETCH.
- Not defined: OP_ADDI is treated as illegal (illegal_op pulse, back to FETCH). Encodings 10/11 are unused.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC, release -> state=0, RegWrite=0 during reset, MemRead=1 after release.
- R-type: instr=0x00430820 (add r1,r2,r3), mem_ready=1 -> states 0,1,6,7; RegWrite=1, writeReg=1 in ALUWB only; readRegA=2, readRegB=3.
- LW with stall: instr=0x8C450004, mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles; MemWB has writeReg=5, MemtoReg=1, RegWrite=1; 7 cycles total.
- SW then BEQ: 0xAC450004 gives MemWrite=1 in MEMWR only and no RegWrite; 0x10430002 gives PCWriteCond=1, PCSource=01 in BRANCH.
- r0/illegal: R-type with rd=0 (0x00430020) -> RegWrite=0 in ALUWB; opcode 0x3F -> illegal_op single pulse in DECODE, next state FETCH.
- ADDI: 0x20410005 -> without MC_IMM_ALU_EN, illegal_op=1; with MC_IMM_ALU_EN, states 0,1,10,11 and writeReg=1, RegWrite=1 in IWB.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: drives register-file addresses/write enable and datapath strobes.
// Latency: J/BEQ 3 cycles, R-type/SW 4, LW 5, plus one cycle per mem_ready=0 in FETCH/MEMRD/MEMWR.
// Backpressure: mem_ready low holds FETCH, MEMRD and MEMWR; it is ignored in every other state.
// Optional feature: define MC_IMM_ALU_EN to execute ADDI through IEXEC/IWB.
module mc_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic [4:0]  readRegA,
    output logic [4:0]  readRegB,
    output logic [4:0]  writeReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        IorD,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        illegal_op,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    // Moore part of the control word, registered alongside the state.
    // fetch/jump_wr/wb are raw enables that get qualified combinationally below.
    typedef struct packed {
        logic       reg_dst;
        logic       mem_to_reg;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       mem_read;
        logic       mem_write;
        logic       pc_write_cond;
        logic       jump_wr;
        logic       fetch;
        logic       wb;
    } ctl_t;

`ifdef MC_IMM_ALU_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    state_t      r_state;
    ctl_t        r_ctl;
    logic [5:0]  w_op;
    logic        w_unused;

    assign w_op     = instr[31:26];
    assign w_unused = &{1'b0, instr[10:0]};

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (IMM_EN && (op == OP_ADDI));
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic rdy);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) n = S_MEMADR;
                else if (op == OP_RTYPE)        n = S_EXEC;
                else if (op == OP_BEQ)          n = S_BRANCH;
                else if (op == OP_J)            n = S_JUMP;
`ifdef MC_IMM_ALU_EN
                else if (op == OP_ADDI)         n = S_IEXEC;
`endif
                else                            n = S_FETCH;
            end
            S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  n = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   n = S_ALUWB;
`ifdef MC_IMM_ALU_EN
            S_IEXEC:  n = S_IWB;
`endif
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.mem_to_reg = 1'b1; c.wb = 1'b1; end
            S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_dst = 1'b1; c.wb = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
            S_JUMP:   begin c.jump_wr = 1'b1; c.pc_source = 2'b10; end
`ifdef MC_IMM_ALU_EN
            S_IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_IWB:    c.wb = 1'b1;
`endif
            default:  c = '0;
        endcase
        return c;
    endfunction

    // State and its decoded control word advance together, so outputs are registered Moore values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ctl   <= decode(S_FETCH);
        end else begin
            r_state <= next_state(r_state, w_op, mem_ready);
            r_ctl   <= decode(next_state(r_state, w_op, mem_ready));
        end
    end

    assign state       = r_state;
    assign readRegA    = instr[25:21];
    assign readRegB    = instr[20:16];
    assign writeReg    = r_ctl.reg_dst ? instr[15:11] : instr[20:16];

    assign RegDst      = r_ctl.reg_dst;
    assign MemtoReg    = r_ctl.mem_to_reg;
    assign IorD        = r_ctl.iord;
    assign ALUSrcA     = r_ctl.alu_src_a;
    assign ALUSrcB     = r_ctl.alu_src_b;
    assign ALUOp       = r_ctl.alu_op;
    assign PCSource    = r_ctl.pc_source;
    assign MemRead     = r_ctl.mem_read;

    // Side-effecting strobes are gated by rst_n so nothing commits while reset is held;
    // RegWrite additionally never targets r0.
    assign RegWrite    = rst_n & r_ctl.wb & (writeReg != 5'd0);
    assign MemWrite    = rst_n & r_ctl.mem_write;
    assign IRWrite     = rst_n & r_ctl.fetch & mem_ready;
    assign PCWrite     = rst_n & (r_ctl.jump_wr | (r_ctl.fetch & mem_ready));
    assign PCWriteCond = rst_n & r_ctl.pc_write_cond;
    assign illegal_op  = rst_n & (r_state == S_DECODE) & ~op_legal(w_op);

endmodule
